// File: rtl/rr_grant_pkg.sv
// rr_grant_pkg: shared constants and state type for the round-robin
// grant encoder (requester count, index width, default watchdog limit).
package rr_grant_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;
endpackage

// File: rtl/rr_grant_encoder_pick.sv
// rr_pick: combinational rotating priority pick.
// Ports: req (requests), ptr (top priority) -> found, idx (winner).
module rr_pick
  import rr_grant_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Doubling the vector turns the rotate into a plain part-select.
  assign dbl = {req, req};
  assign rot = dbl[ptr +: N_REQ];

  always_comb begin
    off   = '0;
    found = |rot;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  // Index width wraps the sum mod N_REQ.
  assign idx = ptr + off;
endmodule

// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: 16-way round-robin arbiter with registered index out.
// Ports: clk, rst (sync, high), req[15:0], rel -> grant_valid,
// grant_idx[3:0], timeout. Macro ARB_TIMEOUT_EN adds the hold watchdog.
module rr_grant_encoder
  import rr_grant_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout
);
  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nx;
  logic [IDX_W-1:0] idx_nx;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             rls;
  logic             new_grant;
  logic             wd_hit;

  // A release re-arbitrates in the same cycle from owner+1.
  assign rls       = (state == GRANTED) && (rel || wd_hit);
  assign pick_ptr  = rls ? grant_idx + 1'b1 : ptr;
  assign new_grant = pick_found && ((state == IDLE) || rls);

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       tmo_nx;

  assign wd_hit = (state == GRANTED)
               && (hold_cnt == 8'(TIMEOUT_CYC - 1));
  // An explicit rel on the limit cycle takes precedence.
  assign tmo_nx = wd_hit && !rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= tmo_nx;
      if (new_grant)
        hold_cnt <= '0;
      else if (state == GRANTED)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      grant_idx <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_found) state_nx = GRANTED;
      GRANTED: if (rls && !pick_found) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ptr_nx = ptr;
    idx_nx = grant_idx;
    if (rls) ptr_nx = pick_ptr;
    if (new_grant) idx_nx = pick_idx;
  end

  assign grant_valid = (state == GRANTED);
endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb_rr_grant_encoder: directed stimulus, per-cycle compare against a
// search-loop model, plus literal checks of key grant points.
module tb_rr_grant_encoder;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = 16'hFFFF;
  logic        rel = 1'b0;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  int m_valid, m_idx, m_ptr, m_held, m_tmo;

  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  rr_grant_encoder #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .timeout(timeout)
  );
`else
  rr_grant_encoder dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .timeout(timeout)
  );
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Walk requesters in priority order from p.
  task automatic arb(input logic [15:0] r, input int p,
                     output bit f, output int w);
    f = 1'b0;
    w = 0;
    for (int k = 0; k < 16; k++) begin
      if (!f && r[(p + k) % 16]) begin
        f = 1'b1;
        w = (p + k) % 16;
      end
    end
  endtask

  always @(posedge clk) begin
    bit f;
    int w;
    int np;
    bit hit;
    if (rst) begin
      m_valid <= 0; m_idx <= 0; m_ptr <= 0;
      m_held <= 0; m_tmo <= 0;
    end else begin
      m_tmo <= 0;
      if (m_valid == 0) begin
        arb(req, m_ptr, f, w);
        if (f) begin
          m_valid <= 1; m_idx <= w; m_held <= 1;
        end
      end else begin
        hit = TO_EN && (m_held == TMO);
        if (rel || hit) begin
          np = (m_idx + 1) % 16;
          m_ptr <= np;
          arb(req, np, f, w);
          m_tmo <= (!rel) ? 1 : 0;
          if (f) begin
            m_idx <= w; m_held <= 1;
          end else begin
            m_valid <= 0;
          end
        end else begin
          m_held <= m_held + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("valid", 32'(grant_valid), 32'(m_valid));
    chk("idx", 32'(grant_idx), 32'(m_idx));
    chk("timeout", 32'(timeout), 32'(m_tmo));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(1);
    chk("rst_valid", 32'(grant_valid), 0);
    chk("rst_idx", 32'(grant_idx), 0);
    step(1);
    chk("rst_tmo", 32'(timeout), 0);
    rst = 1'b0;
    step(1);
    chk("first_idx", 32'(grant_idx), 0);
    chk("first_valid", 32'(grant_valid), 1);

    req = 16'h8421;
    rel = 1'b1;
    step(1); chk("rr_5", 32'(grant_idx), 5);
    step(1); chk("rr_10", 32'(grant_idx), 10);
    step(1); chk("rr_15", 32'(grant_idx), 15);
    step(1); chk("rr_0", 32'(grant_idx), 0);
    chk("rr_valid", 32'(grant_valid), 1);

    req = 16'h4000;
    step(1); chk("wrap_14", 32'(grant_idx), 14);
    req = 16'h8001;
    step(1); chk("wrap_15", 32'(grant_idx), 15);
    step(1); chk("wrap_0", 32'(grant_idx), 0);

    req = 16'h0040;
    step(1); chk("sole_6", 32'(grant_idx), 6);
    step(1); chk("sole_again", 32'(grant_idx), 6);
    chk("sole_valid", 32'(grant_valid), 1);
    req = 16'h0000;
    step(1); chk("sole_idle", 32'(grant_valid), 0);
    chk("idle_hold_idx", 32'(grant_idx), 6);
    step(1); chk("rel_in_idle", 32'(grant_valid), 0);

    rel = 1'b0;
    req = 16'h0008;
    step(1); chk("drop_3", 32'(grant_idx), 3);
    req = 16'h0000;
    step(2);
    chk("drop_hold_v", 32'(grant_valid), 1);
    chk("drop_hold_i", 32'(grant_idx), 3);
    rel = 1'b1;
    step(1); chk("drop_rel", 32'(grant_valid), 0);
    rel = 1'b0;

`ifdef ARB_TIMEOUT_EN
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    req = 16'h0014;
    step(1); chk("to_grant2", 32'(grant_idx), 2);
    step(3);
    chk("to_hold2", 32'(grant_idx), 2);
    chk("to_quiet", 32'(timeout), 0);
    step(1);
    chk("to_idx4", 32'(grant_idx), 4);
    chk("to_pulse", 32'(timeout), 1);
    step(3);
    chk("to_one_cyc", 32'(timeout), 0);
    rel = 1'b1;
    step(1);
    chk("to_rel_idx", 32'(grant_idx), 2);
    chk("to_rel_wins", 32'(timeout), 0);
    rel = 1'b0;
`else
    req = 16'h0100;
    step(1); chk("long_8", 32'(grant_idx), 8);
    step(20);
    chk("long_valid", 32'(grant_valid), 1);
    chk("long_idx", 32'(grant_idx), 8);
    chk("long_tmo", 32'(timeout), 0);
`endif
    req = 16'h0000;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
